// File: rtl/pwm.sv
// 8-bit pulse-width modulator with a programmable clock prescaler.
// Duty is latched only at the 255->0 counter wrap, so a period always completes with the duty it started with.
module pwm #(
    parameter int CLK_SCALER = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] duty_cycle,
    input  logic       oe,
    output logic       out
);

    localparam int PRESC_W = (CLK_SCALER > 1) ? $clog2(CLK_SCALER) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_SCALER - 1);

    generate
        if (CLK_SCALER < 1) begin : g_param_check
            $error("pwm: CLK_SCALER must be at least 1");
        end
    endgenerate

    logic [PRESC_W-1:0] r_presc;
    logic [7:0]         r_cnt;
    logic [7:0]         r_duty;
    logic               r_out;

    logic               w_tick;
    logic               w_wrap;
    logic               w_high;

    // Count-step strobe, period wrap and compare against the latched duty.
    always_comb begin
        w_tick = (r_presc == PRESC_LAST);
        w_wrap = w_tick && (r_cnt == 8'hFF);
        w_high = (r_cnt < r_duty);
    end

    // Prescaler, phase counter, duty latch and registered output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc <= '0;
            r_cnt   <= 8'd0;
            r_duty  <= 8'd0;
            r_out   <= 1'b0;
        end else if (!start) begin
            // While stopped, duty tracks the input so the first period uses it.
            r_presc <= '0;
            r_cnt   <= 8'd0;
            r_duty  <= duty_cycle;
            r_out   <= 1'b0;
        end else begin
            r_out <= oe & w_high;
            if (w_tick) begin
                r_presc <= '0;
                r_cnt   <= r_cnt + 8'd1;
                if (w_wrap) begin
                    r_duty <= duty_cycle;
                end else begin
                    r_duty <= r_duty;
                end
            end else begin
                r_presc <= r_presc + 1'b1;
                r_cnt   <= r_cnt;
                r_duty  <= r_duty;
            end
        end
    end

    assign out = r_out;

endmodule

// File: tb/tb_pwm.sv
// Directed bench for pwm: a CLK_SCALER=5 instance for the nominal flow and a
// CLK_SCALER=1 instance for the 255-duty and wrap-coincident duty-change cases.
module tb_pwm;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] duty;
    logic       oe;
    logic       out5;
    logic       start1;
    logic [7:0] duty1;
    logic       oe1;
    logic       out1;

    int checks;
    int errors;
    int h;

    pwm #(.CLK_SCALER(5)) dut5 (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .duty_cycle (duty),
        .oe         (oe),
        .out        (out5)
    );

    pwm #(.CLK_SCALER(1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .start      (start1),
        .duty_cycle (duty1),
        .oe         (oe1),
        .out        (out1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance n edges, counting samples where the selected output is high.
    task automatic count_high(input bit which, input int n, output int hi);
        hi = 0;
        for (int i = 0; i < n; i++) begin
            step(1);
            if ((which ? out1 : out5) === 1'b1) hi++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        start  = 1'b1;
        oe     = 1'b1;
        duty   = 8'd50;
        start1 = 1'b0;
        oe1    = 1'b1;
        duty1  = 8'd255;

        // Held in reset with run enabled.
        step(3);
        chk("rst_out5", out5, 1'b0);
        chk("rst_out1", out1, 1'b0);
        chk_int("rst_cnt5", int'(dut5.r_cnt), 0);
        chk_int("rst_duty5", int'(dut5.r_duty), 0);

        // Release: first period runs with reset duty 0, then duty 50 latches at wrap.
        rst = 1'b1;
        count_high(1'b0, 1280, h);
        chk_int("post_rst_period1_high", h, 0);
        count_high(1'b0, 1280, h);
        chk_int("post_rst_period2_high", h, 250);

        // CLK_SCALER=1, duty 255: 255 high then 1 low; new duty latched at the wrap edge.
        start1 = 1'b1;
        count_high(1'b1, 255, h);
        chk_int("d255_high", h, 255);
        duty1 = 8'd20;
        step(1);
        chk("d255_low_slot", out1, 1'b0);
        count_high(1'b1, 256, h);
        chk_int("wrap_latch_high", h, 20);

        // Restart at duty 50: first rise 1 clk after start.
        start = 1'b0;
        step(2);
        chk("stopped_out", out5, 1'b0);
        chk_int("stopped_cnt", int'(dut5.r_cnt), 0);
        start = 1'b1;
        step(1);
        chk("first_rise", out5, 1'b1);
        step(249);
        chk("last_high_250", out5, 1'b1);
        step(1);
        chk("first_low_251", out5, 1'b0);
        step(1029);
        chk("last_low_1280", out5, 1'b0);
        step(1);
        chk("period2_rise", out5, 1'b1);

        // Duty 50->10 mid-period: rest of this period keeps 50.
        step(19);
        duty = 8'd10;
        count_high(1'b0, 1260, h);
        chk_int("old_duty_rest_high", h, 230);
        count_high(1'b0, 1280, h);
        chk_int("new_duty_period_high", h, 50);
        step(1);
        chk("p4_rise", out5, 1'b1);
        step(49);
        chk("p4_last_high", out5, 1'b1);
        step(1);
        chk("p4_first_low", out5, 1'b0);

        // Output gate mid-period, phase preserved.
        step(1230);
        chk("p5_rise", out5, 1'b1);
        oe = 1'b0;
        step(1);
        chk("oe_off_next", out5, 1'b0);
        step(10);
        chk("oe_off_hold", out5, 1'b0);
        oe = 1'b1;
        step(1);
        chk("oe_on_resume", out5, 1'b1);
        step(37);
        chk("oe_phase_high", out5, 1'b1);
        step(1);
        chk("oe_phase_low", out5, 1'b0);

        // Stop while high.
        step(1230);
        chk("p6_rise", out5, 1'b1);
        start = 1'b0;
        step(1);
        chk("stop_out", out5, 1'b0);
        chk_int("stop_cnt", int'(dut5.r_cnt), 0);
        chk_int("stop_presc", int'(dut5.r_presc), 0);

        // Duty 0: never high.
        duty = 8'd0;
        step(1);
        start = 1'b1;
        count_high(1'b0, 1280, h);
        chk_int("duty0_high", h, 0);

        // Duty 1: exactly CLK_SCALER high clocks.
        start = 1'b0;
        duty  = 8'd1;
        step(1);
        start = 1'b1;
        count_high(1'b0, 1280, h);
        chk_int("duty1_high", h, 5);

        // Asynchronous reset between edges.
        start = 1'b0;
        duty  = 8'd50;
        step(1);
        start = 1'b1;
        step(1);
        chk("pre_async_high", out5, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_out", out5, 1'b0);
        chk_int("async_rst_cnt", int'(dut5.r_cnt), 0);
        #1;
        rst = 1'b1;
        step(2);
        chk("after_async_duty0", out5, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
